// File: rtl/cache_pkg.sv
// Shared types and constants for the cache valid/dirty state array.
// Build option: CACHE_DIRTY_EN adds the per-way dirty array.
package cache_pkg;

   typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} sweep_state_e;

   localparam logic PRESENT = 1'b1;
   localparam logic ABSENT  = 1'b0;

   localparam int DEF_NUM_SETS = 64;
   localparam int DEF_NUM_WAYS = 2;

endpackage

// File: rtl/cache_sweep_ctrl.sv
// Clear sequencer: walks every set once after reset or a flush request,
// reporting busy and a single-cycle done pulse on the last set.
module cache_sweep_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_SETS = DEF_NUM_SETS,
   parameter int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_req,
   output logic             busy,
   output logic             flush_done,
   output logic             clr_en,
   output logic [IDX_W-1:0] clr_index
);

   sweep_state_e     state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;
   logic             last_set;

   assign last_set = (cnt == IDX_W'(NUM_SETS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SWEEP;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Counter parks on the last set while idle; a flush re-arms it at zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         SWEEP: begin
            if (last_set) state_nxt = IDLE;
            else          cnt_nxt   = cnt + 1'b1;
         end
         IDLE: begin
            if (flush_req) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = SWEEP;
      endcase
   end

   always_comb begin
      busy       = (state == SWEEP);
      flush_done = (state == SWEEP) && last_set;
      clr_en     = (state == SWEEP);
      clr_index  = cnt;
   end

endmodule

// File: rtl/cache_valid_array.sv
// Per-way valid (and optional dirty) state array with write-first read bypass.
// Build option: CACHE_DIRTY_EN enables dirty storage; otherwise rd_dirty is 0.
module cache_valid_array
   import cache_pkg::*;
#(
   parameter  int NUM_SETS = DEF_NUM_SETS,
   parameter  int NUM_WAYS = DEF_NUM_WAYS,
   localparam int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_req,
   output logic                busy,
   output logic                flush_done,
   input  logic                rd_en,
   input  logic [IDX_W-1:0]    rd_index,
   output logic [NUM_WAYS-1:0] rd_valid,
   output logic [NUM_WAYS-1:0] rd_dirty,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_index,
   input  logic [NUM_WAYS-1:0] wr_way,
   input  logic                wr_valid,
   input  logic                wr_dirty
);

   logic             clr_en;
   logic [IDX_W-1:0] clr_index;
   logic             rd_hit;

   function automatic logic [NUM_WAYS-1:0] merge_ways(input logic [NUM_WAYS-1:0] cur,
                                                      input logic [NUM_WAYS-1:0] sel,
                                                      input logic              bit_val);
      return (cur & ~sel) | (sel & {NUM_WAYS{bit_val}});
   endfunction

   cache_sweep_ctrl #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) u_sweep (
      .clk        (clk),
      .rst        (rst),
      .flush_req  (flush_req),
      .busy       (busy),
      .flush_done (flush_done),
      .clr_en     (clr_en),
      .clr_index  (clr_index)
   );

   assign rd_hit = wr_en && (wr_index == rd_index);

   logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
   logic [NUM_WAYS-1:0] rd_valid_p0, rd_valid_p1;

   // Sweep owns the array while busy; host writes are dropped.
   always_ff @(posedge clk) begin
      if (clr_en)     valid_mem[clr_index] <= {NUM_WAYS{ABSENT}};
      else if (wr_en) valid_mem[wr_index]  <= merge_ways(valid_mem[wr_index], wr_way, wr_valid);
   end

   assign rd_valid_p0 = rd_hit ? merge_ways(valid_mem[rd_index], wr_way, wr_valid)
                               : valid_mem[rd_index];

   // ---- stage p0 -> p1: registered lookup result ----
   always_ff @(posedge clk) begin
      if (rst || busy) rd_valid_p1 <= {NUM_WAYS{ABSENT}};
      else if (rd_en)  rd_valid_p1 <= rd_valid_p0;
   end

   assign rd_valid = rd_valid_p1;

`ifdef CACHE_DIRTY_EN
   logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
   logic [NUM_WAYS-1:0] rd_dirty_p0, rd_dirty_p1;

   always_ff @(posedge clk) begin
      if (clr_en)     dirty_mem[clr_index] <= '0;
      else if (wr_en) dirty_mem[wr_index]  <= merge_ways(dirty_mem[wr_index], wr_way, wr_dirty);
   end

   assign rd_dirty_p0 = rd_hit ? merge_ways(dirty_mem[rd_index], wr_way, wr_dirty)
                               : dirty_mem[rd_index];

   always_ff @(posedge clk) begin
      if (rst || busy) rd_dirty_p1 <= '0;
      else if (rd_en)  rd_dirty_p1 <= rd_dirty_p0;
   end

   assign rd_dirty = rd_dirty_p1;
`else
   logic unused_wr_dirty;
   assign unused_wr_dirty = wr_dirty;
   assign rd_dirty        = '0;
`endif

endmodule

// File: tb/tb_cache_valid_array.sv
// Self-checking bench for cache_valid_array (64 sets x 2 ways), scoreboard based.
module tb_cache_valid_array;

   localparam int NS = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush_req = 1'b0;
   logic       busy, flush_done;
   logic       rd_en = 1'b0;
   logic [5:0] rd_index = '0;
   logic [1:0] rd_valid, rd_dirty;
   logic       wr_en = 1'b0;
   logic [5:0] wr_index = '0;
   logic [1:0] wr_way = '0;
   logic       wr_valid = 1'b0;
   logic       wr_dirty = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         idx;
      logic [1:0] v;
      logic [1:0] d;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   logic [1:0] m_valid [NS];
   logic [1:0] m_dirty [NS];

   always #5 clk = ~clk;

   cache_valid_array #(.NUM_SETS(64), .NUM_WAYS(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush_req  (flush_req),
      .busy       (busy),
      .flush_done (flush_done),
      .rd_en      (rd_en),
      .rd_index   (rd_index),
      .rd_valid   (rd_valid),
      .rd_dirty   (rd_dirty),
      .wr_en      (wr_en),
      .wr_index   (wr_index),
      .wr_way     (wr_way),
      .wr_valid   (wr_valid),
      .wr_dirty   (wr_dirty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] exp_dirty(input int idx);
`ifdef CACHE_DIRTY_EN
      return m_dirty[idx];
`else
      return 2'b00;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NS; i++) begin
         m_valid[i] = 2'b00;
         m_dirty[i] = 2'b00;
      end
   endtask

   // Drives a write for the next edge and records its effect in the model.
   task automatic drive_write(input int idx, input logic [1:0] way, input logic v, input logic d);
      wr_en    = 1'b1;
      wr_index = 6'(idx);
      wr_way   = way;
      wr_valid = v;
      wr_dirty = d;
      for (int w = 0; w < 2; w++) begin
         if (way[w]) begin
            m_valid[idx][w] = v;
            m_dirty[idx][w] = d;
         end
      end
   endtask

   // Drives a lookup for the next edge and queues the expected answer.
   task automatic drive_read(input int idx);
      rd_en    = 1'b1;
      rd_index = 6'(idx);
      sb.push_back('{idx, m_valid[idx], exp_dirty(idx)});
   endtask

   task automatic idle_inputs();
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      flush_req = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_reset();
      int n, fd_cnt, fd_at;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
      n_cmp++; if (rd_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 00", rd_valid); end
      n_cmp++; if (rd_dirty !== 2'b00) begin n_bad++; $display("FAIL reset_rd_dirty: got %b want 00", rd_dirty); end
      n = 0; fd_cnt = 0; fd_at = -1;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (flush_done === 1'b1) begin fd_cnt++; fd_at = n; end
         tick();
      end
      n_cmp++; if (n != 64) begin n_bad++; $display("FAIL reset_busy_cycles: got %0d want 64", n); end
      n_cmp++; if (fd_cnt != 1 || fd_at != 64) begin n_bad++; $display("FAIL reset_done_pulse: got count %0d at %0d want 1 at 64", fd_cnt, fd_at); end
      for (int i = 0; i < NS; i++) begin
         drive_read(i);
         tick();
         e = sb.pop_front();
         n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL reset_read set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      end
      idle_inputs();
   endtask

   task automatic test_write_read();
      drive_write(5, 2'b10, 1'b1, 1'b0);
      tick();
      wr_en = 1'b0;
      drive_read(5);
      tick();
      drive_read(6);
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL wr_rd set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      tick();
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL wr_rd set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      rd_en = 1'b0;
      tick();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL rd_hold: got %b want %b", rd_valid, e.v); end
      // multi-hot write, no-op write, then single-way clear on set 12
      drive_write(12, 2'b11, 1'b1, 1'b0);
      tick();
      drive_write(12, 2'b00, 1'b0, 1'b0);
      tick();
      drive_write(13, 2'b01, 1'b1, 1'b0);
      tick();
      wr_en = 1'b0;
      drive_read(12);
      tick();
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL multi_noop set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      drive_write(12, 2'b01, 1'b0, 1'b0);
      tick();
      wr_en = 1'b0;
      drive_read(12);
      tick();
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL way_select set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      idle_inputs();
   endtask

   task automatic test_bypass();
      drive_write(9, 2'b01, 1'b1, 1'b1);
      drive_read(9);
      tick();
      idle_inputs();
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL bypass_valid set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      n_cmp++; if (rd_dirty !== e.d) begin n_bad++; $display("FAIL bypass_dirty set %0d: got %b want %b", e.idx, rd_dirty, e.d); end
   endtask

   task automatic test_dirty();
      drive_write(3, 2'b01, 1'b1, 1'b1);
      tick();
      wr_en = 1'b0;
      drive_read(3);
      tick();
      rd_en = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v) begin n_bad++; $display("FAIL dirty_valid set %0d: got %b want %b", e.idx, rd_valid, e.v); end
      n_cmp++; if (rd_dirty !== e.d) begin n_bad++; $display("FAIL dirty_bit set %0d: got %b want %b", e.idx, rd_dirty, e.d); end
   endtask

   task automatic test_flush();
      int n, fd_cnt, fd_at;
      for (int i = 0; i < NS; i++) begin
         drive_write(i, 2'b11, 1'b1, 1'b1);
         tick();
      end
      wr_en = 1'b0;
      drive_read(NS - 1);
      tick();
      rd_en = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v || rd_dirty !== e.d) begin n_bad++; $display("FAIL fill set %0d: got %b/%b want %b/%b", e.idx, rd_valid, rd_dirty, e.v, e.d); end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      model_clear();
      n = 0; fd_cnt = 0; fd_at = -1;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (flush_done === 1'b1) begin fd_cnt++; fd_at = n; end
         flush_req = (n == 10 || n == 20);
         wr_en     = (n == 15);
         wr_index  = 6'd0;
         wr_way    = 2'b11;
         wr_valid  = 1'b1;
         wr_dirty  = 1'b1;
         rd_en     = 1'b1;
         rd_index  = 6'd1;
         tick();
      end
      idle_inputs();
      n_cmp++; if (n != 64) begin n_bad++; $display("FAIL flush_busy_cycles: got %0d want 64", n); end
      n_cmp++; if (fd_cnt != 1 || fd_at != 64) begin n_bad++; $display("FAIL flush_done_pulse: got count %0d at %0d want 1 at 64", fd_cnt, fd_at); end
      n_cmp++; if (rd_valid !== 2'b00) begin n_bad++; $display("FAIL sweep_rd_held: got %b want 00", rd_valid); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_ignored_req: busy got %b want 0", busy); end
      for (int i = 0; i < NS; i++) begin
         drive_read(i);
         tick();
         e = sb.pop_front();
         n_cmp++; if (rd_valid !== e.v || rd_dirty !== e.d) begin n_bad++; $display("FAIL flush_read set %0d: got %b/%b want %b/%b", e.idx, rd_valid, rd_dirty, e.v, e.d); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_sweep();
      int n, fd_cnt, fd_at;
      drive_write(40, 2'b11, 1'b1, 1'b1);
      tick();
      wr_en = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      model_clear();
      fd_cnt = 0;
      for (int c = 0; c < 29; c++) begin
         if (flush_done === 1'b1) fd_cnt++;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0; fd_at = -1;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (flush_done === 1'b1) begin fd_cnt++; fd_at = n; end
         tick();
      end
      n_cmp++; if (n != 64) begin n_bad++; $display("FAIL midrst_busy_cycles: got %0d want 64", n); end
      n_cmp++; if (fd_cnt != 1 || fd_at != 64) begin n_bad++; $display("FAIL midrst_done_pulse: got count %0d at %0d want 1 at 64", fd_cnt, fd_at); end
      drive_read(40);
      tick();
      drive_read(63);
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v || rd_dirty !== e.d) begin n_bad++; $display("FAIL midrst_read set %0d: got %b/%b want %b/%b", e.idx, rd_valid, rd_dirty, e.v, e.d); end
      tick();
      e = sb.pop_front();
      n_cmp++; if (rd_valid !== e.v || rd_dirty !== e.d) begin n_bad++; $display("FAIL midrst_read set %0d: got %b/%b want %b/%b", e.idx, rd_valid, rd_dirty, e.v, e.d); end
      idle_inputs();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_write_read();
      test_bypass();
      test_dirty();
      test_flush();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
